// File: rtl/uart_port_tx.sv
// Memory-mapped UART transmit port: a small circular byte FIFO feeding an 8N1
// serialiser, with sticky overflow and occupancy readback for the processor.
module uart_port_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_wr_en,
  input  logic [7:0] i_wr_data,
  input  logic       i_clr_ovf,
  output logic       o_tx,
  output logic [3:0] o_status,
  output logic [4:0] o_level
);

  localparam int                PTR_W     = $clog2(FIFO_DEPTH);
  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [4:0]        DEPTH_LVL = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } txState_t;

  txState_t          state, stateNext;
  logic [BAUD_W-1:0] baudCnt, baudNext;
  logic [2:0]        bitIdx, bitNext;
  logic [7:0]        shiftReg, shiftNext;
  logic              txReg, txNext;

  logic [7:0]        fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr, rdPtr;
  logic [4:0]        level;
  logic              overflow;

  logic isEmpty, isFull, pop, push, ovfSet;

  assign isEmpty = (level == 5'd0);
  assign isFull  = (level == DEPTH_LVL);

  // The serialiser drains the FIFO only from IDLE, so a pop frees a slot in the
  // same cycle and lets a write into a full FIFO through.
  assign pop    = (state == IDLE) && !isEmpty;
  assign push   = i_wr_en && (!isFull || pop);
  assign ovfSet = i_wr_en && isFull && !pop;

  // NOTE: storage array has no reset; pointers and occupancy define validity,
  // and leaving it out keeps the array mappable onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push) fifoMem[wrPtr] <= i_wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + 5'd1;
        2'b01:   level <= level - 5'd1;
        default: level <= level;
      endcase
      if (ovfSet)         overflow <= 1'b1;
      else if (i_clr_ovf) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baudCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      txReg    <= 1'b1;
    end else begin
      state    <= stateNext;
      baudCnt  <= baudNext;
      bitIdx   <= bitNext;
      shiftReg <= shiftNext;
      txReg    <= txNext;
    end
  end

  // txNext is the line level for the state being entered, so o_tx comes
  // straight from a flop and changes on the same edge as the state.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    stateNext = state;
    baudNext  = baudCnt;
    bitNext   = bitIdx;
    shiftNext = shiftReg;
    txNext    = txReg;
    unique case (state)
      IDLE: begin
        txNext = 1'b1;
        if (!isEmpty) begin
          stateNext = START;
          baudNext  = '0;
          bitNext   = '0;
          shiftNext = fifoMem[rdPtr];
          txNext    = 1'b0;
        end
      end
      START: begin
        if (baudCnt == BAUD_LAST) begin
          stateNext = DATA;
          baudNext  = '0;
          bitNext   = '0;
          txNext    = shiftReg[0];
        end else begin
          baudNext = baudCnt + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baudCnt == BAUD_LAST) begin
          baudNext = '0;
          if (bitIdx == 3'd7) begin
            stateNext = STOP;
            txNext    = 1'b1;
          end else begin
            bitNext = bitIdx + 3'd1;
            txNext  = shiftReg[bitIdx + 3'd1];
          end
        end else begin
          baudNext = baudCnt + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baudCnt == BAUD_LAST) begin
          stateNext = IDLE;
          baudNext  = '0;
        end else begin
          baudNext = baudCnt + BAUD_W'(1);
        end
      end
      default: begin
        stateNext = IDLE;
        txNext    = 1'b1;
      end
    endcase
  end

  assign o_tx     = txReg;
  assign o_status = {state != IDLE, isFull, isEmpty, overflow};
  assign o_level  = level;

endmodule

// File: tb/tb_uart_port_tx.sv
// Self-checking bench for uart_port_tx: queue/frame-position reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_uart_port_tx;

  localparam int N = 4;
  localparam int D = 4;

  logic       clk    = 1'b0;
  logic       reset  = 1'b0;
  logic       wrEn   = 1'b0;
  logic [7:0] wrData = 8'h00;
  logic       clrOvf = 1'b0;
  logic       tx;
  logic [3:0] status;
  logic [4:0] level;

  int total = 0;
  int bad   = 0;
  bit compareOn = 1'b0;

  uart_port_tx #(.CLKS_PER_BIT(N), .FIFO_DEPTH(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_wr_en  (wrEn),
    .i_wr_data(wrData),
    .i_clr_ovf(clrOvf),
    .o_tx     (tx),
    .o_status (status),
    .o_level  (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a byte queue and, while a frame is on the line, the
  // position inside the 10*N-cycle frame.
  logic [7:0] q[$];
  bit         mBusy;
  int         mPos;
  logic [7:0] mByte;
  bit         mOvf;

  function automatic void modelClear();
    q.delete();
    mBusy = 1'b0;
    mPos  = 0;
    mByte = 8'h00;
    mOvf  = 1'b0;
  endfunction

  function automatic void modelStep();
    bit full, pop, acc, setOvf;
    full   = (q.size() == D);
    pop    = !mBusy && (q.size() > 0);
    acc    = wrEn && (!full || pop);
    setOvf = wrEn && full && !pop;
    if (setOvf)      mOvf = 1'b1;
    else if (clrOvf) mOvf = 1'b0;
    if (mBusy) begin
      mPos++;
      if (mPos == 10 * N) mBusy = 1'b0;
    end else if (pop) begin
      mByte = q.pop_front();
      mBusy = 1'b1;
      mPos  = 0;
    end
    if (acc) q.push_back(wrData);
  endfunction

  function automatic logic mTx();
    int slot;
    if (!mBusy) return 1'b1;
    slot = mPos / N;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return mByte[slot-1];
    return 1'b1;
  endfunction

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) modelClear();
    else        modelStep();
  end

  initial forever begin
    @(negedge clk);
    if (reset && compareOn) begin
      check("cyc_tx", tx, mTx());
      check("cyc_status", status, {mBusy, q.size() == D, q.size() == 0, mOvf});
      check("cyc_level", level, q.size());
    end
  end

  task automatic waitTxLow(input string name);
    int n = 0;
    while (tx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, tx, 1'b0);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while ((status[3] !== 1'b0 || level !== 5'd0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, {status[3], level}, 6'd0);
  endtask

  initial begin
    bit a5Bits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int busyCnt;
    int n;
    logic expBit;

    modelClear();
    repeat (3) @(negedge clk);
    compareOn = 1'b1;
    check("rst_tx", tx, 1'b1);
    check("rst_status", status, 4'b0010);
    check("rst_level", level, 5'd0);

    // Release reset and write on the very next rising edge.
    reset  = 1'b1;
    wrEn   = 1'b1;
    wrData = 8'hA5;
    @(negedge clk);
    wrEn = 1'b0;
    check("first_write_level", level, 5'd1);

    // Single byte 0xA5.
    waitTxLow("a5_start");
    busyCnt = 0;
    for (int i = 0; i < 10 * N; i++) begin
      check($sformatf("a5_tx_%0d", i), tx, a5Bits[i / N]);
      if (status[3]) busyCnt++;
      @(negedge clk);
    end
    check("a5_busy_cycles", busyCnt, 40);
    check("a5_tx_after", tx, 1'b1);
    check("a5_status_after", status, 4'b0010);

    // Six consecutive writes from idle: sixth is dropped.
    for (int i = 0; i < 6; i++) begin
      wrEn   = 1'b1;
      wrData = 8'(8'h10 + i);
      @(negedge clk);
    end
    wrEn = 1'b0;
    check("ovf_status", status, 4'b1101);
    check("ovf_level", level, 5'd4);
    clrOvf = 1'b1;
    @(negedge clk);
    clrOvf = 1'b0;
    check("clr_status", status, 4'b1100);
    waitIdle("ovf_drain");

    // Full FIFO, write on the cycle IDLE pops.
    for (int i = 0; i < 5; i++) begin
      wrEn   = 1'b1;
      wrData = 8'($urandom);
      @(negedge clk);
    end
    wrEn = 1'b0;
    check("full_level", level, 5'd4);
    n = 0;
    while (status[3] !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("full_idle_seen", status[3], 1'b0);
    check("full_idle_level", level, 5'd4);
    wrEn   = 1'b1;
    wrData = 8'h5A;
    @(negedge clk);
    wrEn = 1'b0;
    check("pop_push_level", level, 5'd4);
    check("pop_push_ovf", status[0], 1'b0);
    check("pop_push_busy", status[3], 1'b1);
    waitIdle("full_drain");

    // Back-to-back 0x00 then 0xFF: one idle cycle, 81 cycles total.
    wrEn   = 1'b1;
    wrData = 8'h00;
    @(negedge clk);
    wrData = 8'hFF;
    @(negedge clk);
    wrEn = 1'b0;
    waitTxLow("b2b_start");
    for (int i = 0; i < 81; i++) begin
      expBit = (i < 36) ? 1'b0 : (i < 41) ? 1'b1 : (i < 45) ? 1'b0 : 1'b1;
      check($sformatf("b2b_tx_%0d", i), tx, expBit);
      if (i == 40) check("b2b_gap_busy", status[3], 1'b0);
      if (i == 80) check("b2b_last_busy", status[3], 1'b1);
      @(negedge clk);
    end
    check("b2b_done_busy", status[3], 1'b0);
    check("b2b_done_tx", tx, 1'b1);

    // Reset during data bit 3 with two bytes queued.
    for (int i = 0; i < 3; i++) begin
      wrEn   = 1'b1;
      wrData = 8'($urandom);
      @(negedge clk);
    end
    wrEn = 1'b0;
    n = 0;
    while (!(mBusy && (mPos / N) == 4) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mid_reached_bit3", mBusy && (mPos / N) == 4, 1'b1);
    check("mid_pre_level", level, 5'd2);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1'b1);
    check("mid_rst_level", level, 5'd0);
    check("mid_rst_status", status, 4'b0010);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (60) @(negedge clk);
    check("mid_after_tx", tx, 1'b1);
    check("mid_after_status", status, 4'b0010);

    // Ten bytes paced one per frame, crossing pointer wrap.
    for (int i = 0; i < 10; i++) begin
      wrEn   = 1'b1;
      wrData = 8'($urandom);
      @(negedge clk);
      wrEn = 1'b0;
      waitIdle($sformatf("wrap_idle_%0d", i));
    end

    // Random traffic with overflow pressure and occasional clears.
    repeat (3000) begin
      wrEn   = ($urandom_range(0, 9) < 2);
      wrData = 8'($urandom);
      clrOvf = ($urandom_range(0, 49) == 0);
      @(negedge clk);
    end
    wrEn   = 1'b0;
    clrOvf = 1'b0;
    waitIdle("rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_port_tx.md
UART_PORT_TX -- requirements
Module: uart_port_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4: transmit FIFO entries; power of two, 2..16.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port i_wr_en, input, 1 bit: processor store strobe to the output-port address, one cycle per byte.
REQ-006 Port i_wr_data, input, 8 bits: byte to transmit; low byte of the processor store data.
REQ-007 Port i_clr_ovf, input, 1 bit: clears the overflow flag.
REQ-008 Port o_tx, output, 1 bit: serial line, idle high.
REQ-009 Port o_status, output, 4 bits: {busy, full, empty, overflow}, read back by the processor on PortIn.
REQ-010 Port o_level, output, 5 bits: current FIFO occupancy, 0..FIFO_DEPTH.

Function
REQ-011 FIFO SHALL be circular with read/write pointers wrapping modulo FIFO_DEPTH and a separate occupancy counter.
REQ-012 i_wr_en with FIFO not full SHALL write i_wr_data at the write pointer and increment occupancy on that edge.
REQ-013 i_wr_en with FIFO full and no pop in the same cycle SHALL drop the byte, leave the FIFO unchanged, and set overflow.
REQ-014 i_wr_en with FIFO full and a pop in the same cycle SHALL accept the byte; occupancy stays FIFO_DEPTH; overflow unchanged.
REQ-015 Pop and write in the same cycle on a non-full FIFO SHALL leave occupancy unchanged.
REQ-016 Overflow SHALL be sticky and cleared only by i_clr_ovf or reset; i_clr_ovf and a new overflow in the same cycle SHALL leave overflow set.
REQ-017 empty = (occupancy == 0); full = (occupancy == FIFO_DEPTH); both combinational from registered state.
REQ-018 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-019 IDLE with FIFO non-empty SHALL pop the head byte into the shift register, clear the baud counter, and enter START on the same edge.
REQ-020 START SHALL drive o_tx=0 for exactly CLKS_PER_BIT cycles, then enter DATA with bit index 0.
REQ-021 DATA SHALL drive shift-register bits LSB first, each for CLKS_PER_BIT cycles, then enter STOP after bit 7.
REQ-022 STOP SHALL drive o_tx=1 for CLKS_PER_BIT cycles, then return to IDLE.
REQ-023 A full frame SHALL occupy exactly 10*CLKS_PER_BIT cycles from the first START cycle to the last STOP cycle.
REQ-024 Back-to-back frames SHALL insert exactly one IDLE cycle (o_tx=1) between the STOP of one frame and the START of the next.
REQ-025 busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-026 The baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 at each bit boundary.
REQ-027 o_tx SHALL be registered, with no combinational path from any input.

Reset
REQ-028 Reset assertion SHALL immediately force state IDLE, o_tx=1, pointers=0, occupancy=0, overflow=0, baud counter=0, bit index=0, and shift register=0.
REQ-029 The resulting outputs SHALL be o_status=4'b0010 and o_level=0.
REQ-030 Reset mid-frame SHALL abort the frame and discard all queued bytes; o_tx returns high without completing the stop bit.
REQ-031 The first write SHALL be accepted on the first rising edge after reset deasserts.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-032 Single byte: write 8'hA5 -> o_tx sequence 0,1,0,1,0,0,1,0,1,1, each value held for 4 cycles; busy high for 40 cycles; o_status returns to 4'b0010.
REQ-033 Overflow: write 6 bytes on consecutive cycles starting from idle -> first popped immediately, next 4 fill FIFO, 6th dropped; o_status=4'b1101; i_clr_ovf -> 4'b1100.
REQ-034 Full with simultaneous pop: hold FIFO full and write on the cycle IDLE pops -> write accepted; o_level stays 4; overflow stays 0.
REQ-035 Back-to-back: write 8'h00 then 8'hFF -> the two frames are separated by exactly one high idle cycle; total 81 cycles from the first START.
REQ-036 Reset mid-frame: assert reset during DATA bit 3 with 2 bytes queued -> o_tx=1 and o_level=0 asynchronously; after release there is no transmission until the next write.
REQ-037 Pointer wrap: 10 writes paced at one per frame -> bytes are transmitted in order with correct values across pointer wrap.
